register_file: RTL and testbench

- 32-entry x 64-bit integer register file for the single-cycle RV64 datapath.
- Two combinational read ports (Rs1, Rs2) and one synchronous write port (Rd).
- Register x0 is hardwired to zero.
- Sits between the decode/control stage and the ALU/writeback mux.

---
 rtl/register_file.sv | 50 +++++
 tb/tb_register_file.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 64-bit integer register file for the single-cycle RV64 datapath.
// Two combinational read ports, one synchronous write port, x0 hardwired to zero.
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] Rs1,
    input  logic [ADDR_WIDTH-1:0] Rs2,
    input  logic [ADDR_WIDTH-1:0] Rd,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [0:DEPTH-1];
    logic                  wr_en_d;

    assign wr_en_d = reg_write && (Rd != '0);

    // Entry 0 is only ever cleared, so it stays zero and synthesis can drop it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en_d && (Rd == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= write_data;
                end
            end
        end
    end

    // No write-to-read forwarding: the datapath expects the old value until the edge.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (rst) begin
            read_data1 = regs_q[Rs1];
            read_data2 = regs_q[Rs2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic checked against an array model of the architectural register state.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [4:0]  Rs1, Rs2, Rd;
    logic [63:0] write_data;
    logic [63:0] read_data1, read_data2;

    logic [63:0] model [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .Rd         (Rd),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
    endfunction

    // Architectural rule: a write lands only when enabled, out of reset, and not to x0.
    function automatic void model_write(input logic we, input logic [4:0] rd, input logic [63:0] wd);
        if (we && rd != 5'd0) model[rd] = wd;
    endfunction

    task automatic write_reg(input logic we, input logic [4:0] rd, input logic [63:0] wd);
        @(negedge clk);
        reg_write  = we;
        Rd         = rd;
        write_data = wd;
        @(posedge clk);
        model_write(we, rd, wd);
        #1;
        reg_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        reg_write = 1'b0; Rs1 = 0; Rs2 = 0; Rd = 0; write_data = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            Rs1 = 5'(i);
            Rs2 = 5'(31 - i);
            #1;
            checks++;
            if (read_data1 !== 64'h0 || read_data2 !== 64'h0) begin
                errors++;
                $display("FAIL reset_sweep idx=%0d rd1=%h rd2=%h required 0", i, read_data1, read_data2);
            end
        end
    endtask

    task automatic test_basic();
        write_reg(1'b1, 5'd1, 64'h123456789ABCDEF0);
        Rs1 = 5'd1;
        #1;
        checks++;
        if (read_data1 !== 64'h123456789ABCDEF0) begin
            errors++;
            $display("FAIL basic_write rd1=%h required %h", read_data1, 64'h123456789ABCDEF0);
        end
    endtask

    task automatic test_dual_port();
        write_reg(1'b1, 5'd10, 64'hFEDCBA9876543210);
        Rs1 = 5'd10;
        Rs2 = 5'd1;
        #1;
        checks++;
        if (read_data1 !== 64'hFEDCBA9876543210 || read_data2 !== 64'h123456789ABCDEF0) begin
            errors++;
            $display("FAIL dual_port rd1=%h rd2=%h required %h %h", read_data1, read_data2,
                     64'hFEDCBA9876543210, 64'h123456789ABCDEF0);
        end
        Rs2 = 5'd10;
        #1;
        checks++;
        if (read_data2 !== 64'hFEDCBA9876543210 || read_data1 !== read_data2) begin
            errors++;
            $display("FAIL same_index rd1=%h rd2=%h required %h", read_data1, read_data2, 64'hFEDCBA9876543210);
        end
    endtask

    task automatic test_x0();
        write_reg(1'b1, 5'd0, 64'h1111111111111111);
        Rs1 = 5'd0;
        Rs2 = 5'd0;
        #1;
        checks++;
        if (read_data1 !== 64'h0 || read_data2 !== 64'h0) begin
            errors++;
            $display("FAIL x0_protect rd1=%h rd2=%h required 0", read_data1, read_data2);
        end
    endtask

    task automatic test_write_enable();
        write_reg(1'b0, 5'd1, 64'hDEADBEEF00000000);
        Rs1 = 5'd1;
        #1;
        checks++;
        if (read_data1 !== 64'h123456789ABCDEF0) begin
            errors++;
            $display("FAIL we_gating rd1=%h required %h", read_data1, 64'h123456789ABCDEF0);
        end
    endtask

    task automatic test_no_forward();
        write_reg(1'b1, 5'd5, 64'h0BADF00D0BADF00D);
        @(negedge clk);
        reg_write  = 1'b1;
        Rd         = 5'd5;
        Rs1        = 5'd5;
        write_data = 64'hA5;
        #1;
        checks++;
        if (read_data1 !== 64'h0BADF00D0BADF00D) begin
            errors++;
            $display("FAIL no_forward_before rd1=%h required %h", read_data1, 64'h0BADF00D0BADF00D);
        end
        @(posedge clk);
        model_write(1'b1, 5'd5, 64'hA5);
        #1;
        reg_write = 1'b0;
        checks++;
        if (read_data1 !== 64'hA5) begin
            errors++;
            $display("FAIL no_forward_after rd1=%h required %h", read_data1, 64'hA5);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [4:0]  rd, r1, r2;
        logic [63:0] wd;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 4) == 0) ? r1 : 5'($urandom_range(0, 31));
            @(negedge clk);
            reg_write = we; Rd = rd; write_data = wd; Rs1 = r1; Rs2 = r2;
            #1;
            checks++;
            if (read_data1 !== model[r1] || read_data2 !== model[r2]) begin
                errors++;
                $display("FAIL rand_pre n=%0d rs1=%0d rs2=%0d rd1=%h rd2=%h required %h %h",
                         n, r1, r2, read_data1, read_data2, model[r1], model[r2]);
            end
            @(posedge clk);
            model_write(we, rd, wd);
            #1;
            checks++;
            if (read_data1 !== model[r1] || read_data2 !== model[r2]) begin
                errors++;
                $display("FAIL rand_post n=%0d rs1=%0d rs2=%0d rd1=%h rd2=%h required %h %h",
                         n, r1, r2, read_data1, read_data2, model[r1], model[r2]);
            end
        end
        reg_write = 1'b0;
    endtask

    task automatic test_async_reset();
        write_reg(1'b1, 5'd1, 64'h0101010101010101);
        write_reg(1'b1, 5'd10, 64'h1010101010101010);
        write_reg(1'b1, 5'd31, 64'h3131313131313131);
        Rs1 = 5'd1;
        Rs2 = 5'd31;
        #1;
        checks++;
        if (read_data1 !== 64'h0101010101010101 || read_data2 !== 64'h3131313131313131) begin
            errors++;
            $display("FAIL populate rd1=%h rd2=%h", read_data1, read_data2);
        end
        @(negedge clk);
        #2;
        reg_write  = 1'b1;
        Rd         = 5'd31;
        write_data = 64'hFFFFFFFFFFFFFFFF;
        rst        = 1'b0;
        model_clear();
        #1;
        checks++;
        if (read_data1 !== 64'h0 || read_data2 !== 64'h0) begin
            errors++;
            $display("FAIL async_immediate rd1=%h rd2=%h required 0", read_data1, read_data2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (read_data1 !== 64'h0 || read_data2 !== 64'h0) begin
            errors++;
            $display("FAIL reset_blocks_write rd1=%h rd2=%h required 0", read_data1, read_data2);
        end
        @(negedge clk);
        reg_write = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            Rs1 = 5'(i);
            Rs2 = 5'(i ^ 5'd21);
            #1;
            checks++;
            if (read_data1 !== 64'h0 || read_data2 !== 64'h0) begin
                errors++;
                $display("FAIL post_reset_sweep idx=%0d rd1=%h rd2=%h required 0", i, read_data1, read_data2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dual_port();
        test_x0();
        test_write_enable();
        test_no_forward();
        test_random();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
